// File: rtl/fpa_sched.sv
`timescale 1ns/1ps
// fpa:       combinational single-precision add core. It aligns the smaller
//            operand and adds or subtracts the magnitudes. It returns the sign
//            and biased exponent of the larger operand together with a raw
//            28-bit mantissa: [27] carry, [26] hidden, [25:3] fraction and
//            [2:0] guard/round/sticky.
// fpa_sched: round-robin front end for two requesters. It drives fpa, then
//            normalizes iteratively, rounds to nearest-even and packs the
//            result onto a single tagged response channel.

module fpa (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_sign,
  output logic [7:0]  o_exp,
  output logic [27:0] o_mant
);
  logic        w_a_big;
  logic [31:0] w_big;
  logic [31:0] w_small;
  logic [7:0]  w_e_big;
  logic [7:0]  w_e_small;
  logic [7:0]  w_diff;
  logic [27:0] w_m_big;
  logic [27:0] w_m_small;
  logic [27:0] w_mask;
  logic [27:0] w_shifted;

  // Order operands by magnitude, align the smaller one (shifted-out bits fold into sticky), then add/sub
  always_comb begin
    w_a_big   = (i_a[30:0] >= i_b[30:0]);
    w_big     = w_a_big ? i_a : i_b;
    w_small   = w_a_big ? i_b : i_a;
    // denormals behave as exponent 1 with no hidden bit
    w_e_big   = (w_big[30:23]   == 8'd0) ? 8'd1 : w_big[30:23];
    w_e_small = (w_small[30:23] == 8'd0) ? 8'd1 : w_small[30:23];
    w_diff    = w_e_big - w_e_small;
    w_m_big   = {1'b0, (w_big[30:23]   != 8'd0), w_big[22:0],   3'b000};
    w_m_small = {1'b0, (w_small[30:23] != 8'd0), w_small[22:0], 3'b000};
    w_mask    = ~(28'hFFF_FFFF << w_diff);
    w_shifted = w_m_small >> w_diff;
    w_shifted[0] = w_shifted[0] | (|(w_m_small & w_mask));
    if (w_big[31] ^ w_small[31]) begin
      o_mant = w_m_big - w_shifted;
    end else begin
      o_mant = w_m_big + w_shifted;
    end
    o_sign = w_big[31];
    o_exp  = w_e_big;
  end
endmodule

module fpa_sched #(
  parameter logic        RR_START  = 1'b0,
  parameter logic [31:0] NAN_VALUE = 32'h7FC0_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [31:0] resp_result,
  output logic        busy
);
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_EXEC  = 3'd1,
    S_NORM  = 3'd2,
    S_ROUND = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_last;
  logic        r_id;
  logic        r_nan;
  logic        r_sign;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [9:0]  r_exp;
  logic [27:0] r_mant;
  logic [31:0] r_result;
  logic        r_resp_valid;
  logic        r_resp_id;
  logic        r_busy;

  logic        w_grant;
  logic        w_idle;
  logic        w_accept;
  logic        w_nan;
  logic        w_norm_shl;
  logic        w_fpa_sign;
  logic [7:0]  w_fpa_exp;
  logic [27:0] w_fpa_mant;
  logic        w_inc;
  logic [23:0] w_frac_sum;
  logic [9:0]  w_exp_rnd;
  logic [22:0] w_frac_rnd;
  logic [31:0] w_packed;

  fpa u_fpa (
    .i_a    (r_a),
    .i_b    (r_b),
    .o_sign (w_fpa_sign),
    .o_exp  (w_fpa_exp),
    .o_mant (w_fpa_mant)
  );

  // Grant: a lone valid wins; on a tie the port not granted last wins
  always_comb begin
    w_grant = 1'b0;
    if (req0_valid && req1_valid) begin
      w_grant = ~r_last;
    end else if (req1_valid) begin
      w_grant = 1'b1;
    end else begin
      w_grant = 1'b0;
    end
  end

  assign w_idle     = (r_state == S_IDLE);
  assign w_accept   = w_idle && (req0_valid || req1_valid);
  assign req0_ready = w_idle && req0_valid && !w_grant;
  assign req1_ready = w_idle && req1_valid &&  w_grant;

  assign w_nan      = (r_a[30:23] == 8'hFF) || (r_b[30:23] == 8'hFF);
  // another left shift is needed only while no leading one, non-zero and not yet denormal
  assign w_norm_shl = !r_mant[27] && !r_mant[26] && (r_mant != 28'd0) && (r_exp != 10'd1);

  // Round-to-nearest-even on the normalized mantissa and pack the IEEE word
  always_comb begin
    w_inc      = r_mant[2] & (r_mant[1] | r_mant[0] | r_mant[3]);
    w_frac_sum = {1'b0, r_mant[25:3]} + {23'd0, w_inc};
    w_exp_rnd  = r_exp + {9'd0, w_frac_sum[23]};
    w_frac_rnd = w_frac_sum[23] ? 23'd0 : w_frac_sum[22:0];
    if (w_exp_rnd >= 10'd255) begin
      w_packed = {r_sign, 8'hFF, 23'd0};
    end else begin
      w_packed = {r_sign, w_exp_rnd[7:0], w_frac_rnd};
    end
  end

  // Next-state logic; a NaN operand skips NORM so ROUND only selects the forced value
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = S_EXEC;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_EXEC: begin
        if (w_nan) begin
          w_next = S_ROUND;
        end else begin
          w_next = S_NORM;
        end
      end
      S_NORM: begin
        if (w_norm_shl) begin
          w_next = S_NORM;
        end else begin
          w_next = S_ROUND;
        end
      end
      S_ROUND: w_next = S_RESP;
      S_RESP: begin
        if (resp_ready) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_RESP;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Operand latch, fpa capture, iterative normalization and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a       <= 32'd0;
      r_b       <= 32'd0;
      r_id      <= 1'b0;
      r_last    <= ~RR_START;
      r_sign    <= 1'b0;
      r_exp     <= 10'd0;
      r_mant    <= 28'd0;
      r_nan     <= 1'b0;
      r_result  <= 32'd0;
      r_resp_id <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a    <= w_grant ? req1_a : req0_a;
            r_b    <= w_grant ? req1_b : req0_b;
            r_id   <= w_grant;
            r_last <= w_grant;
          end
        end
        S_EXEC: begin
          r_sign <= w_fpa_sign;
          r_exp  <= {2'b00, w_fpa_exp};
          r_mant <= w_fpa_mant;
          r_nan  <= w_nan;
        end
        S_NORM: begin
          if (r_mant[27]) begin
            r_mant <= {1'b0, r_mant[27:2], r_mant[1] | r_mant[0]};
            r_exp  <= r_exp + 10'd1;
          end else if (r_mant[26]) begin
            r_mant <= r_mant;
          end else if (r_mant == 28'd0) begin
            r_sign <= 1'b0;
            r_exp  <= 10'd0;
          end else if (r_exp == 10'd1) begin
            r_exp  <= 10'd0;
          end else begin
            r_mant <= {r_mant[26:0], 1'b0};
            r_exp  <= r_exp - 10'd1;
          end
        end
        S_ROUND: begin
          r_result  <= r_nan ? NAN_VALUE : w_packed;
          r_resp_id <= r_id;
        end
        default: begin
          r_result <= r_result;
        end
      endcase
    end
  end

  // Registered status outputs derived from the upcoming state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_valid <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_resp_valid <= (w_next == S_RESP);
      r_busy       <= (w_next != S_IDLE);
    end
  end

  assign resp_valid  = r_resp_valid;
  assign resp_id     = r_resp_id;
  assign resp_result = r_result;
  assign busy        = r_busy;
endmodule

// File: tb/tb_fpa_sched.sv
`timescale 1ns/1ps
// Directed and randomized bench for fpa_sched. Expected sums come from an
// exact big-integer reference adder with round-to-nearest-even.
module tb_fpa_sched;
  localparam logic RR0 = 1'b0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        resp_valid, resp_ready, resp_id, busy;
  logic [31:0] resp_result;

  int errors = 0;
  int checks = 0;

  fpa_sched dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  // Exact reference: value = sig * 2^(e-150); sum as wide integers, then RNE to single
  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    int ea, eb, e_big, e_small, e_low, d, p, be, sh;
    logic [23:0] sa, sb, sig_big, sig_small;
    logic s_big, s_small, s;
    logic [127:0] mb, ms, m, q, rem, half;
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return 32'h7FC0_0000;
    ea = (a[30:23] == 8'd0) ? 1 : int'(a[30:23]);
    eb = (b[30:23] == 8'd0) ? 1 : int'(b[30:23]);
    sa = {(a[30:23] != 8'd0), a[22:0]};
    sb = {(b[30:23] != 8'd0), b[22:0]};
    if (ea >= eb) begin
      sig_big = sa; sig_small = sb; e_big = ea; e_small = eb; s_big = a[31]; s_small = b[31];
    end else begin
      sig_big = sb; sig_small = sa; e_big = eb; e_small = ea; s_big = b[31]; s_small = a[31];
    end
    d = e_big - e_small;
    if (d <= 60) begin
      mb = 128'(sig_big) << d;
      ms = 128'(sig_small);
      e_low = e_small;
    end else begin
      mb = 128'(sig_big) << 62;
      ms = (sig_small != 24'd0) ? 128'd1 : 128'd0;
      e_low = e_big - 62;
    end
    if (s_big == s_small) begin
      m = mb + ms; s = s_big;
    end else if (mb >= ms) begin
      m = mb - ms; s = s_big;
    end else begin
      m = ms - mb; s = s_small;
    end
    if (m == 128'd0) return 32'd0;
    p = 0;
    for (int i = 0; i < 128; i++) if (m[i]) p = i;
    be = p + e_low - 23;
    if (be >= 1) begin
      sh = p - 23;
    end else begin
      sh = 1 - e_low;
      be = 0;
    end
    if (sh <= 0) begin
      q = m << (-sh);
    end else begin
      q = m >> sh;
      rem = m & ((128'd1 << sh) - 128'd1);
      half = 128'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 128'd1;
    end
    if (be > 0 && q[24]) begin
      q = q >> 1;
      be++;
    end
    if (be == 0 && q[23]) be = 1;
    if (be >= 255) return {s, 8'hFF, 23'd0};
    return {s, be[7:0], q[22:0]};
  endfunction

  // One transaction on a single port; optional backpressure of 'hold' cycles
  task automatic run_txn(input logic port, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expv, input int exp_lat, input int hold);
    int k;
    if (port) begin
      req1_a = a; req1_b = b; req1_valid = 1'b1;
    end else begin
      req0_a = a; req0_b = b; req0_valid = 1'b1;
    end
    #1;
    k = 0;
    while (!(port ? req1_ready : req0_ready) && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk1("grant", port ? req1_ready : req0_ready, 1'b1);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    k = 0;
    while (!resp_valid && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk1("resp_valid", resp_valid, 1'b1);
    if (exp_lat >= 0) chk32("latency", 32'(k), 32'(exp_lat));
    else chk1("latency_range", (k >= 3 && k <= 29), 1'b1);
    chk32("result", resp_result, expv);
    chk1("resp_id", resp_id, port);
    for (int i = 0; i < hold; i++) begin
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      @(negedge clk);
      chk1("hold_valid", resp_valid, 1'b1);
      chk32("hold_result", resp_result, expv);
      chk1("hold_id", resp_id, port);
      chk1("hold_ready0", req0_ready, 1'b0);
      chk1("hold_ready1", req1_ready, 1'b0);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk1("resp_drop", resp_valid, 1'b0);
    chk1("idle_busy", busy, 1'b0);
  endtask

  initial begin
    logic        exp_g, model_last;
    int          ngrant, nresp, k, mode, ea;
    logic [31:0] ra, rb;

    rst_n = 1'b0; resp_ready = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 32'd0; req0_b = 32'd0; req1_a = 32'd0; req1_b = 32'd0;
    #12;
    chk1("rst_resp_valid", resp_valid, 1'b0);
    chk1("rst_resp_id", resp_id, 1'b0);
    chk32("rst_resp_result", resp_result, 32'd0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_ready0", req0_ready, 1'b0);
    chk1("rst_ready1", req1_ready, 1'b0);

    // Arbitration: both requesters valid from reset, consumer always ready
    req0_a = 32'h3F80_0000; req0_b = 32'h3F80_0000;
    req1_a = 32'h3F80_0000; req1_b = 32'h4000_0000;
    req0_valid = 1'b1; req1_valid = 1'b1; resp_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    model_last = ~RR0;
    ngrant = 0;
    nresp = 0;
    for (int c = 0; c < 80 && nresp < 4; c++) begin
      if (req0_ready || req1_ready) begin
        exp_g = ~model_last;
        chk1("rr_grant", req1_ready, exp_g);
        chk1("rr_exclusive", req0_ready & req1_ready, 1'b0);
        model_last = exp_g;
        ngrant++;
      end
      if (resp_valid) begin
        exp_g = RR0 ^ nresp[0];
        chk1("rr_id", resp_id, exp_g);
        chk32("rr_result", resp_result, exp_g ? ref_add(req1_a, req1_b) : ref_add(req0_a, req0_b));
        nresp++;
        if (nresp == 4) begin
          req0_valid = 1'b0;
          req1_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    chk32("rr_resp_count", 32'(nresp), 32'd4);
    chk32("rr_grant_count", 32'(ngrant), 32'd4);
    resp_ready = 1'b0;
    @(negedge clk);
    chk1("rr_idle", busy, 1'b0);

    // Directed arithmetic cases with exact latencies
    run_txn(1'b0, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 3, 0);
    run_txn(1'b0, 32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 3, 0);
    run_txn(1'b0, 32'h3F80_0000, 32'hBF7F_FFFF, 32'h3380_0000, 27, 0);
    run_txn(1'b1, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 3, 0);
    run_txn(1'b0, 32'h7F80_0000, 32'h3F80_0000, 32'h7FC0_0000, 2, 0);
    // Backpressure: consumer stalls five cycles
    run_txn(1'b1, 32'h4040_0000, 32'h3F80_0000, 32'h4080_0000, 3, 5);

    // Reset in the middle of the deep-shift normalization
    req0_a = 32'h3F80_0000; req0_b = 32'hBF7F_FFFF; req0_valid = 1'b1;
    #1;
    k = 0;
    while (!req0_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk1("deep_grant", req0_ready, 1'b1);
    @(negedge clk);
    req0_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk1("norm_busy", busy, 1'b1);
    chk1("norm_no_resp", resp_valid, 1'b0);
    rst_n = 1'b0;
    #1;
    chk1("mid_rst_valid", resp_valid, 1'b0);
    chk1("mid_rst_id", resp_id, 1'b0);
    chk32("mid_rst_result", resp_result, 32'd0);
    chk1("mid_rst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(1'b1, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 3, 0);

    // Randomized operands against the reference adder
    for (int n = 0; n < 40; n++) begin
      ra = $urandom;
      rb = $urandom;
      mode = $urandom_range(0, 5);
      case (mode)
        1: rb = {~ra[31], ra[30:23], rb[22:0]};
        2: begin
          ea = $urandom_range(1, 250);
          ra[30:23] = 8'(ea);
          rb[30:23] = 8'(ea + int'($urandom_range(0, 3)));
        end
        3: begin
          ra[30:23] = 8'($urandom_range(0, 2));
          rb[30:23] = 8'($urandom_range(0, 2));
        end
        4: begin
          ra[30:23] = 8'($urandom_range(250, 254));
          rb[30:23] = 8'($urandom_range(250, 254));
        end
        5: ra[30:23] = 8'hFF;
        default: ra = ra;
      endcase
      run_txn(1'($urandom_range(0, 1)), ra, rb, ref_add(ra, rb),
              (ra[30:23] == 8'hFF || rb[30:23] == 8'hFF) ? 2 : -1, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
